seq_detect_fsm: RTL and testbench

Parametrised serial sequence detector, successor to the team's fixed 8-state `go`-driven Moore FSM. It watches a 1-bit `go` stream and raises a one-cycle registered `op` pulse each time a run-time-loadable W-bit pattern completes. It adds a sample-enable input, an overlap/non-overlap mode and a saturating match counter, and sits between a serial input source and control/status logic.

---
 rtl/seq_detect_fsm_if.sv | 25 ++
 rtl/seq_detect_fsm.sv | 124 ++++++++++++
 tb/tb_seq_detect_fsm.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_fsm_if.sv
// Serial detector bus: sample stream, pattern load/control, and match status.
interface seq_detect_fsm_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
);
  logic             go;
  logic             valid;
  logic             pat_load;
  logic [W-1:0]     pat_in;
  logic             overlap;
  logic             clr_cnt;
  logic             op;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output go, valid, pat_load, pat_in, overlap, clr_cnt,
    input  op, match_cnt, armed
  );

  modport slave (
    input  go, valid, pat_load, pat_in, overlap, clr_cnt,
    output op, match_cnt, armed
  );
endinterface

// File: rtl/seq_detect_fsm.sv
// Loadable W-bit serial pattern detector with overlap mode and a saturating match counter.
module seq_detect_fsm #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detect_fsm_if.slave   bus
);

  localparam int unsigned FILL_W = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HUNT = 2'd1;
  localparam logic [1:0] HIT  = 2'd2;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Out-of-range pattern widths fail elaboration on an undefined module.
  generate
    if (W < 2 || W > 16) begin : g_bad_w
      seq_detect_fsm_illegal_width u_illegal_width ();
    end
  endgenerate

  logic [1:0]        st, st_n;
  logic [W-1:0]      pat, pat_n;
  logic [W-1:0]      hist, hist_n;
  logic [FILL_W-1:0] fill, fill_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              op_q;
  logic              armed_q;

  logic [W-1:0]      hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              sample;
  logic              match;

  // Candidate history/fill for the current sample and the match decision.
  always_comb begin
    hist_shift = {hist[W-2:0], bus.go};
    fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    sample     = ((st == HUNT) || (st == HIT)) && bus.valid && !bus.pat_load;
    match      = sample && (fill_inc == FILL_FULL) && (hist_shift == pat);
  end

  // Next-state and datapath update; pat_load overrides any sample.
  always_comb begin
    st_n   = st;
    pat_n  = pat;
    hist_n = hist;
    fill_n = fill;

    case (st)
      IDLE: begin
        if (bus.pat_load) begin
          pat_n  = bus.pat_in;
          hist_n = '0;
          fill_n = '0;
          st_n   = HUNT;
        end
      end

      HUNT, HIT: begin
        if (bus.pat_load) begin
          pat_n  = bus.pat_in;
          hist_n = '0;
          fill_n = '0;
          st_n   = HUNT;
        end else begin
          st_n = HUNT;
          if (bus.valid) begin
            hist_n = hist_shift;
            fill_n = fill_inc;
          end
          if (match) begin
            st_n   = HIT;
            fill_n = bus.overlap ? FILL_FULL : '0;
          end
        end
      end

      default: begin
        st_n = IDLE;
      end
    endcase
  end

  // Match counter: clear wins over increment but a coincident match leaves one.
  always_comb begin
    cnt_n = cnt;
    if (bus.clr_cnt) begin
      cnt_n = match ? CNT_W'(1) : '0;
    end else if (match && (cnt != CNT_MAX)) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= IDLE;
      pat     <= '0;
      hist    <= '0;
      fill    <= '0;
      cnt     <= '0;
      op_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      st      <= st_n;
      pat     <= pat_n;
      hist    <= hist_n;
      fill    <= fill_n;
      cnt     <= cnt_n;
      op_q    <= (st_n == HIT);
      armed_q <= (st_n != IDLE);
    end
  end

  assign bus.op        = op_q;
  assign bus.match_cnt = cnt;
  assign bus.armed     = armed_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Scoreboard bench for seq_detect_fsm: an 8-bit and a 2-bit counter instance share one stimulus.
module tb_seq_detect_fsm;

  logic clk;
  logic reset;

  seq_detect_fsm_if #(.W(4), .CNT_W(8)) bus8 ();
  seq_detect_fsm_if #(.W(4), .CNT_W(2)) bus2 ();

  assign bus2.go       = bus8.go;
  assign bus2.valid    = bus8.valid;
  assign bus2.pat_load = bus8.pat_load;
  assign bus2.pat_in   = bus8.pat_in;
  assign bus2.overlap  = bus8.overlap;
  assign bus2.clr_cnt  = bus8.clr_cnt;

  seq_detect_fsm #(.W(4), .CNT_W(8)) dut   (.clk(clk), .reset(reset), .bus(bus8));
  seq_detect_fsm #(.W(4), .CNT_W(2)) dut_s (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       op;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic       armed;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_op     = 0;
  logic [7:0] op_hist;

  // Reference model state
  logic       m_armed;
  logic [3:0] m_pat, m_hist;
  int         m_fill;
  logic [7:0] m_cnt8;
  logic [1:0] m_cnt2;
  logic       m_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_armed = 1'b0; m_pat = '0; m_hist = '0; m_fill = 0;
    m_cnt8 = '0; m_cnt2 = '0; m_op = 1'b0;
  endtask

  // Drive one cycle, predict the result, then compare after the edge.
  task automatic step(input logic g, input logic v, input logic pl, input logic cc);
    logic       match;
    logic [3:0] hs;
    int         fn;
    exp_t       e;
    exp_t       o;
    bus8.go = g; bus8.valid = v; bus8.pat_load = pl; bus8.clr_cnt = cc;

    match = 1'b0;
    if (pl) begin
      m_pat = bus8.pat_in; m_hist = '0; m_fill = 0; m_armed = 1'b1;
    end else if (m_armed && v) begin
      hs    = {m_hist[2:0], g};
      fn    = (m_fill + 1 > 4) ? 4 : m_fill + 1;
      match = (fn == 4) && (hs == m_pat);
      m_hist = hs;
      m_fill = match ? (bus8.overlap ? 4 : 0) : fn;
    end
    m_op = match;
    if (cc) begin
      m_cnt8 = match ? 8'd1 : 8'd0;
      m_cnt2 = match ? 2'd1 : 2'd0;
    end else if (match) begin
      if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
      if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
    end
    e.op = m_op; e.cnt8 = m_cnt8; e.cnt2 = m_cnt2; e.armed = m_armed;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      o = exp_q.pop_front();
      check("op",     32'(bus8.op),        32'(o.op));
      check("cnt8",   32'(bus8.match_cnt), 32'(o.cnt8));
      check("cnt2",   32'(bus2.match_cnt), 32'(o.cnt2));
      check("armed",  32'(bus8.armed),     32'(o.armed));
    end
    if (bus8.op) n_op++;
    op_hist = {op_hist[6:0], bus8.op};
    bus8.pat_load = 1'b0; bus8.clr_cnt = 1'b0;
  endtask

  task automatic load(input logic [3:0] p, input logic ov, input logic cc);
    bus8.pat_in  = p;
    bus8.overlap = ov;
    step(1'b0, 1'b0, 1'b1, cc);
  endtask

  initial begin
    logic [6:0] stream;
    reset = 1'b1;
    bus8.go = 1'b0; bus8.valid = 1'b0; bus8.pat_load = 1'b0;
    bus8.pat_in = '0; bus8.overlap = 1'b0; bus8.clr_cnt = 1'b0;
    op_hist = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_op",    32'(bus8.op),        32'd0);
    check("rst_cnt",   32'(bus8.match_cnt), 32'd0);
    check("rst_armed", 32'(bus8.armed),     32'd0);
    reset = 1'b0;

    // Idle ignores samples until a pattern is loaded
    n_op = 0;
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_ops", 32'(n_op), 32'd0);

    // Overlapping matches on 1011
    load(4'b1011, 1'b1, 1'b1);
    n_op = 0;
    stream = 7'b1011011;
    for (int i = 6; i >= 0; i--) step(stream[i], 1'b1, 1'b0, 1'b0);
    check("ovl_ops", 32'(n_op), 32'd2);
    check("ovl_cnt", 32'(bus8.match_cnt), 32'd2);

    // Non-overlap restarts after the first match
    load(4'b1011, 1'b0, 1'b1);
    n_op = 0;
    for (int i = 6; i >= 0; i--) step(stream[i], 1'b1, 1'b0, 1'b0);
    check("novl_ops", 32'(n_op), 32'd1);
    check("novl_cnt", 32'(bus8.match_cnt), 32'd1);

    // All-ones with a valid gap between bits 2 and 3
    load(4'b1111, 1'b1, 1'b1);
    n_op = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("gap_ops", 32'(n_op), 32'd3);
    check("gap_run", 32'(op_hist[3:0]), 32'b0111);
    check("gap_cnt", 32'(bus8.match_cnt), 32'd3);

    // Saturation of the narrow counter
    load(4'b1111, 1'b1, 1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("sat_cnt2", 32'(bus2.match_cnt), 32'd3);
    check("sat_cnt8", 32'(bus8.match_cnt), 32'd5);

    // Clear coincident with a match leaves one
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_hit_op",  32'(bus8.op),        32'd1);
    check("clr_hit_cnt", 32'(bus8.match_cnt), 32'd1);

    // Load coincident with the completing bit discards it
    load(4'b1011, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    bus8.pat_in = 4'b1011;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("ld_hit_op",  32'(bus8.op),        32'd0);
    check("ld_hit_cnt", 32'(bus8.match_cnt), 32'd1);
    n_op = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("reload_ops", 32'(n_op), 32'd1);

    // Asynchronous reset in the middle of a partial match
    load(4'b1011, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_armed", 32'(bus8.armed),     32'd0);
    check("mid_rst_cnt",   32'(bus8.match_cnt), 32'd0);
    check("mid_rst_op",    32'(bus8.op),        32'd0);
    m_reset();
    #2 reset = 1'b0;
    n_op = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_op", 32'(bus8.op), 32'd0);
    load(4'b1011, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("fresh_3_ops", 32'(n_op), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("fresh_4_op", 32'(bus8.op), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
